// File: rtl/dll_pkg.sv
// Shared DLL definitions: sequencer states, default loop constants and the SAR start code.
// The SAR and the sequencer must agree on SAR_START_CODE so that a clear lands on mid-code.
package dll_pkg;

  localparam int NBITS_DEF       = 10;
  localparam int SETTLE_CYC_DEF  = 8;
  localparam int AVG_LEN_DEF     = 4;
  localparam int TRACK_LIMIT_DEF = 4;

  localparam logic [NBITS_DEF-1:0] SAR_START_CODE = 10'b1000000000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DECIDE,
    ST_STEP
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dll_pd_window.sv
// Phase-detector window: counts pd_lag ones over AVG_LEN sample cycles and reports majority/unanimity.
// Result is valid the cycle after the last enabled sample; no backpressure, the FSM paces it.
module dll_pd_window #(
  parameter int AVG_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic pd_lag,
  output logic last,
  output logic lag_major,
  output logic unanimous
);

  localparam int OW = $clog2(AVG_LEN + 1);
  localparam int CW = (AVG_LEN > 1) ? $clog2(AVG_LEN) : 1;

  logic [OW-1:0] ones;
  logic [CW-1:0] cnt;
  logic [OW:0]   ones_x2;

  assign last = en && (cnt == CW'(AVG_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones <= '0;
      cnt  <= '0;
    end else if (clr) begin
      ones <= '0;
      cnt  <= '0;
    end else if (en) begin
      ones <= ones + OW'(pd_lag);
      cnt  <= last ? '0 : cnt + 1'b1;
    end
  end

  // A tie (exactly half the samples lagging) resolves to lag.
  assign ones_x2   = {ones, 1'b0};
  assign lag_major = (ones_x2 >= (OW + 1)'(AVG_LEN));
  assign unanimous = (ones == '0) || (ones == OW'(AVG_LEN));

endmodule

// File: rtl/dll_sar_sequencer.sv
// DLL SAR initiator: clear, settle, sample-window, decide, step; locks after NBITS decisions, then tracks.
// Decision period SETTLE_CYC+AVG_LEN+2 cycles; enable low aborts to IDLE next cycle, no partial step.
module dll_sar_sequencer
  import dll_pkg::*;
#(
  parameter int NBITS       = NBITS_DEF,
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int AVG_LEN     = AVG_LEN_DEF,
  parameter int TRACK_LIMIT = TRACK_LIMIT_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         pd_lag,
  output logic                         comp,
  output logic                         sar_step,
  output logic                         sar_clr,
  output logic                         busy,
  output logic                         lock,
  output logic [$clog2(NBITS+1)-1:0]   step_cnt,
  output logic [7:0]                   relock_cnt
);

  localparam int SCW = $clog2(NBITS + 1);
  localparam int SW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int TW  = $clog2(TRACK_LIMIT + 1);

  state_t         state, state_nxt;
  logic [SW-1:0]  settle_cnt, settle_nxt;
  logic [TW-1:0]  track, track_nxt, track_upd;
  logic           track_hit;
  logic           comp_nxt, lock_nxt;
  logic [SCW-1:0] step_nxt;
  logic [7:0]     relock_nxt;

  logic win_last, win_major, win_unan;

  dll_pd_window #(
    .AVG_LEN (AVG_LEN)
  ) u_window (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == ST_SETTLE),
    .en        (state == ST_SAMPLE),
    .pd_lag    (pd_lag),
    .last      (win_last),
    .lag_major (win_major),
    .unanimous (win_unan)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    settle_nxt = '0;
    track_nxt  = track;
    comp_nxt   = comp;
    lock_nxt   = lock;
    step_nxt   = step_cnt;
    relock_nxt = relock_cnt;

    // comp still holds the previous window's direction while in DECIDE.
    if (win_unan && (win_major == comp)) track_upd = track + 1'b1;
    else if (win_unan)                   track_upd = TW'(1);
    else                                 track_upd = '0;
    track_hit = lock && (track_upd == TW'(TRACK_LIMIT));

    case (state)
      ST_IDLE:   if (enable) state_nxt = ST_CLR;
      ST_CLR:    state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (settle_cnt == SW'(SETTLE_CYC - 1)) state_nxt = ST_SAMPLE;
        else                                   settle_nxt = settle_cnt + 1'b1;
      end
      ST_SAMPLE: if (win_last) state_nxt = ST_DECIDE;
      ST_DECIDE: begin
        comp_nxt  = win_major;
        state_nxt = ST_STEP;
        if (lock) begin
          track_nxt = track_upd;
          if (track_hit) begin
            state_nxt  = ST_CLR;
            relock_nxt = sat_inc8(relock_cnt);
          end
        end
      end
      ST_STEP: begin
        // step_cnt already counts this step, so lock follows the NBITS-th strobe.
        if (step_cnt == SCW'(NBITS)) lock_nxt = 1'b1;
        state_nxt = ST_SETTLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase

    if (state_nxt == ST_STEP && step_cnt != SCW'(NBITS)) step_nxt = step_cnt + 1'b1;

    if (state_nxt == ST_CLR) begin
      step_nxt  = '0;
      track_nxt = '0;
      lock_nxt  = 1'b0;
    end

    if (!enable) begin
      state_nxt  = ST_IDLE;
      settle_nxt = '0;
      track_nxt  = '0;
      lock_nxt   = 1'b0;
      comp_nxt   = comp;
      step_nxt   = step_cnt;
      relock_nxt = relock_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
      track      <= '0;
      comp       <= 1'b0;
      lock       <= 1'b0;
      step_cnt   <= '0;
      relock_cnt <= '0;
      sar_step   <= 1'b0;
      sar_clr    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      settle_cnt <= settle_nxt;
      track      <= track_nxt;
      comp       <= comp_nxt;
      lock       <= lock_nxt;
      step_cnt   <= step_nxt;
      relock_cnt <= relock_nxt;
      sar_step   <= (state_nxt == ST_STEP);
      sar_clr    <= (state_nxt == ST_CLR);
      busy       <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_dll_sar_sequencer.sv
// Directed bench for dll_sar_sequencer: search timing, lock, tracking relock, tie rule, abort, async reset.
// Cycle k is the period following the k-th rising edge after enable is raised in cycle 0.
module tb_dll_sar_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       pd_lag;
  logic       comp, sar_step, sar_clr, busy, lock;
  logic [3:0] step_cnt;
  logic [7:0] relock_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dll_sar_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pd_lag     (pd_lag),
    .comp       (comp),
    .sar_step   (sar_step),
    .sar_clr    (sar_clr),
    .busy       (busy),
    .lock       (lock),
    .step_cnt   (step_cnt),
    .relock_cnt (relock_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 with enable just raised.
  task automatic restart();
    rst    = 1'b1;
    enable = 1'b0;
    pd_lag = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    enable = 1'b1;
  endtask

  function automatic int exp_cnt(input int n);
    return (n < 10) ? n + 1 : 10;
  endfunction

  initial begin
    int act;
    int nsteps;

    // Reset state and idle behaviour
    rst    = 1'b1;
    enable = 1'b0;
    pd_lag = 1'b0;
    tick();
    tick();
    check("rst_comp", comp, 0);
    check("rst_step", sar_step, 0);
    check("rst_clr", sar_clr, 0);
    check("rst_busy", busy, 0);
    check("rst_lock", lock, 0);
    check("rst_step_cnt", step_cnt, 0);
    check("rst_relock_cnt", relock_cnt, 0);
    rst = 1'b0;
    act = 0;
    repeat (50) begin
      tick();
      if (busy || sar_step || sar_clr || lock) act++;
    end
    check("idle_activity", act, 0);

    // Constant lead: full search, comp=0
    restart();
    nsteps = 0;
    for (int k = 1; k <= 160; k++) begin
      tick();
      if (k == 1) begin
        check("t1_clr_at_1", sar_clr, 1);
        check("t1_busy_at_1", busy, 1);
        check("t1_cnt_at_1", step_cnt, 0);
      end
      if (k == 2) check("t1_clr_at_2", sar_clr, 0);
      if (sar_step) begin
        check("t1_step_cyc", k, 15 + 14 * nsteps);
        check("t1_step_comp", comp, 0);
        check("t1_step_cnt", step_cnt, exp_cnt(nsteps));
        nsteps++;
      end
      if (k == 141) check("t1_lock_141", lock, 0);
      if (k == 142) check("t1_lock_142", lock, 1);
    end
    check("t1_nsteps", nsteps, 11);

    // Constant lag: lock, three tracking steps, then relock
    restart();
    pd_lag = 1'b1;
    nsteps = 0;
    for (int k = 1; k <= 205; k++) begin
      tick();
      if (sar_step) begin
        check("t2_step_cyc", k, 15 + 14 * nsteps);
        check("t2_step_comp", comp, 1);
        check("t2_step_cnt", step_cnt, exp_cnt(nsteps));
        nsteps++;
      end
      if (k == 142) check("t2_lock_142", lock, 1);
      if (k == 196) begin
        check("t2_lock_196", lock, 1);
        check("t2_relock_196", relock_cnt, 0);
      end
      if (k == 197) begin
        check("t2_lock_197", lock, 0);
        check("t2_clr_197", sar_clr, 1);
        check("t2_relock_197", relock_cnt, 1);
        check("t2_step_197", sar_step, 0);
        check("t2_cnt_197", step_cnt, 0);
      end
    end
    check("t2_nsteps", nsteps, 13);
    for (int k = 206; k <= 345; k++) tick();
    check("t2_relocked", lock, 1);
    check("t2_relock_cnt", relock_cnt, 1);

    // Asynchronous reset between edges while locked
    #3;
    rst = 1'b1;
    #1;
    check("arst_lock", lock, 0);
    check("arst_relock_cnt", relock_cnt, 0);
    check("arst_busy", busy, 0);
    check("arst_step_cnt", step_cnt, 0);
    check("arst_comp", comp, 0);

    // Alternating pd_lag: tie windows resolve to lag and never relock
    restart();
    nsteps = 0;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (sar_step) begin
        check("t3_step_comp", comp, 1);
        nsteps++;
      end
      pd_lag = ~pd_lag;
    end
    check("t3_nsteps", nsteps, 28);
    check("t3_lock", lock, 1);
    check("t3_relock_cnt", relock_cnt, 0);

    // Enable dropped mid-window, then re-enabled
    restart();
    act = 0;
    for (int k = 1; k <= 90; k++) begin
      tick();
      if (k == 67) enable = 1'b0;
      if (k == 68) begin
        check("t4_busy_68", busy, 0);
        check("t4_cnt_hold", step_cnt, 4);
        check("t4_lock_68", lock, 0);
      end
      if (k >= 68 && (sar_step || sar_clr || busy)) act++;
    end
    check("t4_no_partial", act, 0);
    enable = 1'b1;
    nsteps = 0;
    for (int k = 91; k <= 110; k++) begin
      tick();
      if (k == 91) begin
        check("t4_clr_91", sar_clr, 1);
        check("t4_cnt_91", step_cnt, 0);
      end
      if (sar_step) begin
        check("t4_step_cyc", k, 105);
        check("t4_step_cnt", step_cnt, 1);
        nsteps++;
      end
    end
    check("t4_nsteps", nsteps, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
